// File: rtl/jk_excitation_driver_if.sv
// Target handshake between a sequencing controller and jk_excitation_driver.
// The controller (master) offers a target state word; the driver (slave)
// signals when it can take one.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_valid;
    logic             tgt_ready;

    modport master (
        output tgt_data,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt_data,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Write side for an external bank of JK flip-flops sharing clk.
// A captured target word is turned into per-bit J/K excitation from the
// current bank readback, driven for exactly one clock, then the readback is
// compared with the target (with optional re-drive attempts on mismatch).
// Build option: define JK_TOGGLE_DC_EN to resolve excitation don't-cares to 1
// (changing bits toggle with J=K=1); otherwise don't-cares resolve to 0.
module jk_excitation_driver #(
    parameter int WIDTH   = 4,
    parameter int RETRIES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jk_excitation_driver_if.slave tgt,
    input  logic [WIDTH-1:0]     q_in,
    output logic [WIDTH-1:0]     j_out,
    output logic [WIDTH-1:0]     k_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] target_reg, target_next;
    logic [WIDTH-1:0] j_reg, j_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic [2:0]       retry_reg, retry_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             busy_reg, busy_next;
    logic             ready_reg, ready_next;

    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // In IDLE the excitation is built for the incoming word; on a re-drive it
    // is rebuilt for the captured target against the fresh readback.
    assign exc_tgt = (state_reg == IDLE) ? tgt.tgt_data : target_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_TOGGLE_DC_EN
            // Don't-cares as 1: changing bits toggle, held bits force their level.
            assign exc_j[gi] = q_in[gi] | exc_tgt[gi];
            assign exc_k[gi] = ~(q_in[gi] & exc_tgt[gi]);
`else
            // Don't-cares as 0: only set a 0->1 bit, only reset a 1->0 bit.
            assign exc_j[gi] = ~q_in[gi] & exc_tgt[gi];
            assign exc_k[gi] = q_in[gi] & ~exc_tgt[gi];
`endif
        end
    endgenerate

    // State and output registers; async reset also kills an in-flight drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            retry_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            j_reg      <= j_next;
            k_reg      <= k_next;
            retry_reg  <= retry_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            busy_reg   <= busy_next;
            ready_reg  <= ready_next;
        end
    end

    // Next-state and next-output logic; J/K default to 0 so they are only
    // non-zero during a DRIVE cycle.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        j_next      = '0;
        k_next      = '0;
        retry_next  = retry_reg;
        done_next   = 1'b0;
        err_next    = err_reg & ~err_clr;

        case (state_reg)
            IDLE: begin
                if (tgt.tgt_valid && ready_reg) begin
                    target_next = tgt.tgt_data;
                    j_next      = exc_j;
                    k_next      = exc_k;
                    retry_next  = '0;
                    state_next  = DRIVE;
                end
            end
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (q_in == target_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (retry_reg < RETRY_MAX) begin
                    retry_next = retry_reg + 3'd1;
                    j_next     = exc_j;
                    k_next     = exc_k;
                    state_next = DRIVE;
                end else begin
                    // Failing compare sets err even if err_clr is high.
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next  = (state_next == DRIVE) || (state_next == CHECK);
        ready_next = (state_next == IDLE);
    end

    assign j_out         = j_reg;
    assign k_out         = k_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign tgt.tgt_ready = ready_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver (WIDTH=4, RETRIES=1) with a behavioural JK
// bank on q_in. Expected excitation/result records are queued when a target
// is offered and compared when the transfer's outputs appear.
// Honours JK_TOGGLE_DC_EN in its excitation model.
module tb_jk_excitation_driver;

    localparam int W = 4;

    typedef struct {
        logic [3:0] j;
        logic [3:0] k;
        logic       e;
        logic [3:0] bank;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] q_in;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;

    logic [3:0] bank;
    logic [3:0] load_val;
    logic       load_en;
    logic       stuck;

    int total;
    int bad;
    exp_t sb[$];

    jk_excitation_driver_if #(.WIDTH(W)) tif ();

    jk_excitation_driver #(.WIDTH(W), .RETRIES(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgt     (tif.slave),
        .q_in    (q_in),
        .j_out   (j_out),
        .k_out   (k_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_clr (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK bank; can be preloaded or frozen to model a stuck bank.
    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else if (!stuck) begin
            for (int i = 0; i < W; i++) begin
                case ({j_out[i], k_out[i]})
                    2'b01:   bank[i] <= 1'b0;
                    2'b10:   bank[i] <= 1'b1;
                    2'b11:   bank[i] <= ~bank[i];
                    default: bank[i] <= bank[i];
                endcase
            end
        end
    end
    assign q_in = bank;

    // Excitation table, one bit at a time: returns {j, k}.
    function automatic logic [7:0] model_exc(input logic [3:0] q, input logic [3:0] t);
        logic [3:0] j;
        logic [3:0] k;
        for (int i = 0; i < 4; i++) begin
            case ({q[i], t[i]})
`ifdef JK_TOGGLE_DC_EN
                2'b00: begin j[i] = 1'b0; k[i] = 1'b1; end
                2'b01: begin j[i] = 1'b1; k[i] = 1'b1; end
                2'b10: begin j[i] = 1'b1; k[i] = 1'b1; end
                default: begin j[i] = 1'b1; k[i] = 1'b0; end
`else
                2'b00: begin j[i] = 1'b0; k[i] = 1'b0; end
                2'b01: begin j[i] = 1'b1; k[i] = 1'b0; end
                2'b10: begin j[i] = 1'b0; k[i] = 1'b1; end
                default: begin j[i] = 1'b0; k[i] = 1'b0; end
`endif
            endcase
        end
        return {j, k};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [3:0] q, input logic [3:0] t, input logic e,
                            input logic [3:0] bank_after, input int lat);
        exp_t x;
        logic [7:0] jk;
        jk = model_exc(q, t);
        x.j = jk[7:4];
        x.k = jk[3:0];
        x.e = e;
        x.bank = bank_after;
        x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic load_bank(input logic [3:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Offer a target at a negedge; returns at the negedge after the accept edge.
    task automatic offer(input logic [3:0] t);
        int w;
        tif.tgt_data  = t;
        tif.tgt_valid = 1'b1;
        w = 0;
        while (tif.tgt_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("offer_ready_timeout", 32'(w < 20), 32'd1);
        @(negedge clk);
    endtask

    // Called in the DRIVE cycle of a transfer; follows it to its done pulse.
    task automatic check_xfer(input string tag);
        exp_t e;
        int   lat;
        int   busy_cnt;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_drive_j"}, 32'(j_out), 32'(e.j));
        chk({tag, "_drive_k"}, 32'(k_out), 32'(e.k));
        chk({tag, "_drive_busy"}, 32'(busy), 32'd1);
        chk({tag, "_drive_ready"}, 32'(tif.tgt_ready), 32'd0);
        chk({tag, "_drive_done"}, 32'(done), 32'd0);
        lat = 0;
        busy_cnt = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (lat == 2 && e.lat == 4) begin
                chk({tag, "_retry_j"}, 32'(j_out), 32'(e.j));
                chk({tag, "_retry_k"}, 32'(k_out), 32'(e.k));
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
        chk({tag, "_err"}, 32'(err), 32'(e.e));
        chk({tag, "_bank"}, 32'(bank), 32'(e.bank));
        chk({tag, "_done_ready"}, 32'(tif.tgt_ready), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_jk"}, 32'({j_out, k_out}), 32'd0);
        $display("xfer %s: latency=%0d err=%0b bank=%b j=%b k=%b", tag, lat, err, bank, e.j, e.k);
    endtask

    initial begin
        logic [7:0] jk;
        int         done_seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        err_clr = 1'b0;
        tif.tgt_valid = 1'b0;
        tif.tgt_data  = 4'b0000;
        load_en  = 1'b0;
        load_val = 4'b0000;
        stuck    = 1'b0;

        // Reset state
        load_bank(4'b0000);
        @(negedge clk);
        chk("rst_ready", 32'(tif.tgt_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_jk", 32'({j_out, k_out}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(tif.tgt_ready), 32'd1);

        // 1: 0000 -> 1010
        push_exp(4'b0000, 4'b1010, 1'b0, 4'b1010, 2);
        offer(4'b1010);
        tif.tgt_valid = 1'b0;
        check_xfer("t1");
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // 2: 1100 -> 0110
        load_bank(4'b1100);
        push_exp(4'b1100, 4'b0110, 1'b0, 4'b0110, 2);
        offer(4'b0110);
        tif.tgt_valid = 1'b0;
        check_xfer("t2");

        // 3: stuck bank, retry then error; err_clr clears
        load_bank(4'b0000);
        stuck = 1'b1;
        push_exp(4'b0000, 4'b0001, 1'b1, 4'b0000, 4);
        offer(4'b0001);
        tif.tgt_valid = 1'b0;
        check_xfer("t3");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(err), 32'd0);

        // 3b: err_clr held through a failing transfer; set wins
        err_clr = 1'b1;
        push_exp(4'b0000, 4'b0001, 1'b1, 4'b0000, 4);
        offer(4'b0001);
        tif.tgt_valid = 1'b0;
        check_xfer("t3b");
        err_clr = 1'b0;
        @(negedge clk);
        chk("t3b_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3b_err_clr", 32'(err), 32'd0);
        stuck = 1'b0;

        // 4: target equals bank
        load_bank(4'b0101);
        push_exp(4'b0101, 4'b0101, 1'b0, 4'b0101, 2);
        offer(4'b0101);
        tif.tgt_valid = 1'b0;
        check_xfer("t4");

        // 5: back-to-back with valid held; data change after accept ignored
        push_exp(4'b0101, 4'b0011, 1'b0, 4'b0011, 2);
        push_exp(4'b0011, 4'b1111, 1'b0, 4'b1111, 2);
        offer(4'b0011);
        tif.tgt_data = 4'b1111;
        check_xfer("t5a");
        @(negedge clk);
        tif.tgt_valid = 1'b0;
        check_xfer("t5b");

        // 6: reset during DRIVE
        load_bank(4'b0000);
        offer(4'b1111);
        tif.tgt_valid = 1'b0;
        jk = model_exc(4'b0000, 4'b1111);
        chk("t6_drive_j", 32'(j_out), 32'(jk[7:4]));
        rst_n = 1'b0;
        #1;
        chk("t6_async_jk", 32'({j_out, k_out}), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_ready", 32'(tif.tgt_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        chk("t6_rel_ready", 32'(tif.tgt_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("t6_no_done", 32'(done_seen), 32'd0);
        chk("t6_bank_held", 32'(bank), 32'd0);
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
